// File: rtl/aes128_req_ctrl_if.sv
// Request, core-side and response signal bundle for aes128_req_ctrl.
// slave is the controller view; master is the host/core environment view.
interface aes128_req_ctrl_if #(
    parameter int TAG_W = 4
);
    logic               req_valid_i;
    logic               req_ready_o;
    logic               req_decrypt_i;
    logic [127:0]       req_key_i;
    logic [127:0]       req_data_i;
    logic [TAG_W-1:0]   req_tag_i;

    logic               load_o;
    logic               decrypt_o;
    logic [127:0]       key_o;
    logic [127:0]       data_o;
    logic               core_done_i;
    logic [127:0]       core_data_i;

    logic               rsp_valid_o;
    logic               rsp_ready_i;
    logic [127:0]       rsp_data_o;
    logic [TAG_W-1:0]   rsp_tag_o;
    logic               rsp_decrypt_o;
    logic               rsp_timeout_o;

    modport slave (
        input  req_valid_i, req_decrypt_i, req_key_i, req_data_i, req_tag_i,
        output req_ready_o,
        output load_o, decrypt_o, key_o, data_o,
        input  core_done_i, core_data_i,
        output rsp_valid_o, rsp_data_o, rsp_tag_o, rsp_decrypt_o, rsp_timeout_o,
        input  rsp_ready_i
    );

    modport master (
        output req_valid_i, req_decrypt_i, req_key_i, req_data_i, req_tag_i,
        input  req_ready_o,
        input  load_o, decrypt_o, key_o, data_o,
        output core_done_i, core_data_i,
        input  rsp_valid_o, rsp_data_o, rsp_tag_o, rsp_decrypt_o, rsp_timeout_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/aes128_req_ctrl.sv
// Host-side request controller for the aes128 core: one load per request,
// operands held until the response is taken, with tag return and timeout.
module aes128_req_ctrl #(
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    aes128_req_ctrl_if.slave    bus,
    output logic                busy_o,
    output logic [CNT_W-1:0]    timeout_cnt_o,
    output logic [CNT_W-1:0]    spurious_cnt_o
);
    localparam int WAIT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

    state_t             state, state_next;
    logic               accept, wait_done, wait_expire;
    logic               load_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               hold_decrypt;
    logic [127:0]       hold_key, hold_data;
    logic [TAG_W-1:0]   hold_tag;
    logic [127:0]       rsp_data;
    logic               rsp_timeout;
    logic [CNT_W-1:0]   timeout_cnt, spurious_cnt;

    // Done is tested before the terminal count so it wins a same-cycle tie.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        wait_done   = 1'b0;
        wait_expire = 1'b0;
        case (state)
            IDLE: if (bus.req_valid_i) begin
                accept     = 1'b1;
                state_next = LOAD;
            end
            LOAD: state_next = WAIT;
            WAIT: if (bus.core_done_i) begin
                wait_done  = 1'b1;
                state_next = RESP;
            end else if (wait_cnt == WAIT_LAST) begin
                wait_expire = 1'b1;
                state_next  = RESP;
            end
            RESP: if (bus.rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // load_o comes straight from a flop so it cannot glitch during decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q       <= 1'b0;
            wait_cnt     <= '0;
            hold_decrypt <= 1'b0;
            hold_key     <= '0;
            hold_data    <= '0;
            hold_tag     <= '0;
            rsp_data     <= '0;
            rsp_timeout  <= 1'b0;
            timeout_cnt  <= '0;
            spurious_cnt <= '0;
        end else begin
            load_q <= accept;
            if (accept) begin
                hold_decrypt <= bus.req_decrypt_i;
                hold_key     <= bus.req_key_i;
                hold_data    <= bus.req_data_i;
                hold_tag     <= bus.req_tag_i;
            end
            if (state == LOAD)
                wait_cnt <= '0;
            else if (state == WAIT && !wait_done && !wait_expire)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_done) begin
                rsp_data    <= bus.core_data_i;
                rsp_timeout <= 1'b0;
            end
            if (wait_expire) begin
                rsp_data    <= '0;
                rsp_timeout <= 1'b1;
                if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + CNT_W'(1);
            end
            if (bus.core_done_i && state != WAIT && spurious_cnt != '1)
                spurious_cnt <= spurious_cnt + CNT_W'(1);
        end
    end

    assign bus.req_ready_o   = (state == IDLE);
    assign bus.load_o        = load_q;
    assign bus.decrypt_o     = hold_decrypt;
    assign bus.key_o         = hold_key;
    assign bus.data_o        = hold_data;
    assign bus.rsp_valid_o   = (state == RESP);
    assign bus.rsp_data_o    = rsp_data;
    assign bus.rsp_tag_o     = hold_tag;
    assign bus.rsp_decrypt_o = hold_decrypt;
    assign bus.rsp_timeout_o = rsp_timeout;
    assign busy_o            = (state != IDLE);
    assign timeout_cnt_o     = timeout_cnt;
    assign spurious_cnt_o    = spurious_cnt;
endmodule

// File: doc/aes128_req_ctrl.md
Name: aes128_req_ctrl

Overview:
Host-side request controller that drives the aes128 core's load/decrypt/key/data inputs. It accepts encrypt or decrypt requests on a valid/ready channel, issues exactly one single-cycle load to the core, and holds the mode and operands stable until the core completes. It returns the result on a valid/ready response channel, with a per-request tag and timeout detection. Sits between the bus/DMA front-end and the aes128 core instance.

Parameters:
TAG_W, 4, width of request/response tag.
TIMEOUT_CYC, 64, max WAIT cycles before timeout; legal range 2..2^16-1.
CNT_W, 8, width of the saturating error counters.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid_i  in  1  request valid.
req_ready_o  out  1  request ready.
req_decrypt_i  in  1  1=decrypt, 0=encrypt.
req_key_i  in  128  cipher key.
req_data_i  in  128  plaintext/ciphertext block.
req_tag_i  in  TAG_W  request tag.
load_o  out  1  core load pulse (to core load_i).
decrypt_o  out  1  core mode (to core decrypt_i).
key_o  out  128  core key.
data_o  out  128  core data block.
core_done_i  in  1  core result valid (one-cycle pulse).
core_data_i  in  128  core result block.
rsp_valid_o  out  1  response valid.
rsp_ready_i  in  1  response ready.
rsp_data_o  out  128  result block; 0 on timeout.
rsp_tag_o  out  TAG_W  tag of the originating request.
rsp_decrypt_o  out  1  mode of the originating request.
rsp_timeout_o  out  1  1 = core did not complete.
busy_o  out  1  state != IDLE.
timeout_cnt_o  out  CNT_W  saturating timeout count.
spurious_cnt_o  out  CNT_W  saturating count of core_done_i outside WAIT.

Behaviour:
- Reset (async assert, sync deassert at the flops): state=IDLE. All outputs 0 except req_ready_o=1. Counters 0, holding registers 0. Reset mid-operation aborts immediately; load_o never glitches high.
- FSM states: IDLE, LOAD, WAIT, RESP.
- IDLE: req_ready_o=1. On req_valid_i&req_ready_o, capture decrypt/key/data/tag into holding registers and go to LOAD.
- LOAD: lasts exactly 1 cycle; load_o=1; go to WAIT with wait counter=0. A request accepted in cycle N gives load_o high in cycle N+1.
- decrypt_o/key_o/data_o are driven from the holding registers in LOAD, WAIT and RESP. They are stable from load until the response is accepted. In IDLE they hold their last value. load_o is high only in LOAD.
- WAIT:
  - core_done_i=1: capture core_data_i into rsp_data_o, rsp_timeout_o=0, go to RESP.
  - Else the wait counter increments. When the counter reaches TIMEOUT_CYC-1 without done: rsp_data_o=0, rsp_timeout_o=1, timeout_cnt_o++ (saturating), go to RESP.
  - If done and the timeout terminal count fall in the same cycle, done wins (no timeout).
- RESP: rsp_valid_o=1; rsp_data/tag/decrypt/timeout held stable while rsp_ready_i=0. On rsp_ready_i=1, go to IDLE. rsp_valid_o drops the next cycle; req_ready_o rises the next cycle.
- Response latency is done+1 cycle. Minimum request-to-request spacing is 4 cycles plus core latency.
- core_done_i in IDLE, LOAD or RESP: ignored for data; spurious_cnt_o++ (saturating).
- Counters saturate at 2^CNT_W-1 and never wrap. They clear only on reset.
- Invariants: load_o never high on two consecutive cycles. At most one outstanding core operation. req_ready_o and rsp_valid_o are never both 1.

Test Plan:
- Encrypt, core model latency 10: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, tag 3 -> load_o one cycle after accept with decrypt_o=0; rsp_data_o 69c4e0d86a7b0430d8cdb78070b4c55a, tag 3, timeout 0.
- Decrypt same key, data 69c4e0d86a7b0430d8cdb78070b4c55a, tag 5 -> decrypt_o=1 during load; rsp 00112233445566778899aabbccddeeff, rsp_decrypt_o=1.
- Core never asserts done, TIMEOUT_CYC=8 -> rsp_valid_o 8 cycles after the WAIT entry; rsp_data_o=0, rsp_timeout_o=1, timeout_cnt_o=1. Repeat 300 times with CNT_W=8 -> counter stops at 255.
- rsp_ready_i held low 20 cycles while req_valid_i=1 -> req_ready_o=0 throughout, rsp fields stable, no second load_o; after ready, next load_o follows correctly.
- core_done_i pulsed in IDLE and during RESP; done coincident with timeout terminal count -> spurious_cnt_o=2, response holds core data with timeout 0.
- rst_n asserted in WAIT -> all outputs return to reset values asynchronously; after release, a new request completes normally with correct tag.
